axis_data_generator: RTL and testbench
======================================

// Module: axis_data_generator
// PURPOSE
//  AXI4-Stream test-traffic source for the 400GbE datapath (drives the MAC TX streaming port).
//  While enabled, starts one packet of pkt_length beats every `period` clocks.
//  Each beat carries a deterministic, checkable pattern.
//  Used for bring-up and throughput tests in place of real payload.
// PARAMETERS
//  G_AXIS_DATA_WIDTH  1024  tdata width in bits; must be a multiple of 64 (>=64)
// PORTS
//  axis_streaming_data_clk        in   1      sole clock
//  axis_streaming_arst            in   1      asynchronous reset, active-high
//  axis_data_gen_enable           in   1      run control, sampled on clk
//  pkt_length                     in   16     packet length in beats (0 treated as 1)
//  period                         in   16     clocks between packet starts (0 treated as 1)
//  axis_streaming_data_tx_tdata   out  W      payload pattern
//  axis_streaming_data_tx_tvalid  out  1      beat valid
//  axis_streaming_data_tx_tuser   out  1      error flag, always 0
//  axis_streaming_data_tx_tkeep   out  W/8    byte enables, all ones when tvalid
//  axis_streaming_data_tx_tlast   out  1      last beat of packet
//  axis_streaming_data_tx_tready  in   1      sink ready
// BEHAVIOUR
//  - Reset (async assert, sync release): tvalid=0, tlast=0, tuser=0, tkeep=0, tdata=0.
//    Reset also clears all counters, pkt_seq and FSM to IDLE. Reset mid-packet aborts immediately.
//  - All outputs are registered. Beat transfer occurs on tvalid&tready.
//  - FSM IDLE -> SEND: on a clock where enable=1.
//    First beat is valid the next cycle (1-cycle latency).
//    pkt_length and period are latched at each packet start.
//  - SEND: beat_idx counts transferred beats 0..L-1; tlast=1 exactly on beat_idx==L-1.
//    After the last transfer: WAIT, or SEND directly (see period rule).
//  - Period counter: reset to 0 on the cycle the first beat is presented.
//    Increments every clock thereafter, independent of tready.
//    Next packet's first beat is presented when the counter reaches P
//    AND the previous tlast has transferred AND enable=1.
//    If L>=P (or backpressure delays), packets run back-to-back; no idle beat between them.
//  - WAIT: tvalid=0 until the period rule fires. If enable=0 there, go to IDLE.
//  - Enable deassert mid-packet: the current packet completes in full, then no new packet starts.
//  - tready=0: hold tdata/tkeep/tlast/tvalid stable; never deassert tvalid before transfer.
//  - Pattern: lane i (64-bit, i=0..W/64-1) = {pkt_seq[31:0], beat_idx[15:0], i[15:0]}.
//    pkt_seq starts at 0 after reset, increments after each tlast transfer, wraps at 2^32.
//  - tkeep=all ones on valid beats, 0 otherwise; tuser constant 0.
//  - Changing pkt_length/period mid-packet does not affect the current packet.
// TESTING
//  1 Reset 10ns then idle: all outputs 0, no tvalid while enable=0.
//  2 W=1024,L=64,P=128, enable high 50 clks, tready=1:
//    exactly one 64-beat packet, tlast on beat 63, pkt_seq=0, tkeep=all ones; no second packet.
//  3 L=4,P=10, enable held: tvalid high 4 clks, low 6, repeating.
//    pkt_seq increments 0,1,2,...; lane pattern matches per beat.
//  4 L=8,P=4: back-to-back packets, tvalid continuously high, tlast every 8th beat.
//  5 Random tready toggling with L=16: outputs stable while stalled.
//    16 transfers per packet, beat_idx contiguous.
//  6 Assert reset mid-packet: outputs go to 0 asynchronously;
//    after release with enable=1, restart at pkt_seq=0, beat_idx=0.

Source files
------------

// File: rtl/axis_data_generator_if.sv
// AXI4-Stream transmit bus carried between the traffic generator and its sink.
// The master drives payload and framing, and the slave returns tready.
interface axis_data_generator_if #(
    parameter int unsigned G_AXIS_DATA_WIDTH = 1024
);
    localparam int unsigned KEEP_W = G_AXIS_DATA_WIDTH / 8;

    logic [G_AXIS_DATA_WIDTH-1:0] tdata;
    logic                         tvalid;
    logic                         tuser;
    logic [KEEP_W-1:0]            tkeep;
    logic                         tlast;
    logic                         tready;

    modport master (output tdata, output tvalid, output tuser, output tkeep, output tlast,
                    input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tkeep, input tlast,
                    output tready);
endinterface

// File: rtl/axis_data_generator.sv
// AXI4-Stream test-traffic source: one packet of pkt_length beats every `period` clocks,
// each 64-bit lane tagged with {pkt_seq, beat_idx, lane} so the sink can check it.
module axis_data_generator #(
    parameter int unsigned G_AXIS_DATA_WIDTH = 1024
) (
    input  logic                   axis_streaming_data_clk,
    input  logic                   axis_streaming_arst,
    input  logic                   axis_data_gen_enable,
    input  logic [15:0]            pkt_length,
    input  logic [15:0]            period,
    axis_data_generator_if.master  axis_streaming_data_tx
);
    localparam int unsigned W      = G_AXIS_DATA_WIDTH;
    localparam int unsigned LANES  = W / 64;
    localparam int unsigned KEEP_W = W / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic [15:0]       beat_q,     beat_d;
    logic [15:0]       last_idx_q, last_idx_d;
    logic [15:0]       per_q,      per_d;
    logic [15:0]       cnt_q,      cnt_d;
    logic [31:0]       seq_q,      seq_d;
    logic              tvalid_q,   tvalid_d;
    logic              tlast_q,    tlast_d;
    logic [W-1:0]      tdata_q,    tdata_d;
    logic [KEEP_W-1:0] tkeep_q,    tkeep_d;
    logic              xfer_c;
    logic              period_done_c;
    logic              start_c;

    function automatic logic [W-1:0] pattern(input logic [31:0] seq, input logic [15:0] beat);
        logic [W-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            p[64*i +: 64] = {seq, beat, 16'(i)};
        end
        return p;
    endfunction

    // Next-state and next-output computation; every output is re-registered each clock.
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        last_idx_d = last_idx_q;
        per_d      = per_q;
        cnt_d      = cnt_q;
        seq_d      = seq_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        start_c    = 1'b0;

        xfer_c        = tvalid_q & axis_streaming_data_tx.tready;
        period_done_c = (17'(cnt_q) + 17'd1) >= 17'(per_q);

        // Saturate at the period so long backpressure cannot wrap the counter.
        if (cnt_q < per_q) begin
            cnt_d = cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (axis_data_gen_enable) begin
                    start_c = 1'b1;
                end
            end
            S_SEND: begin
                if (xfer_c) begin
                    if (tlast_q) begin
                        seq_d = seq_q + 32'd1;
                        if (axis_data_gen_enable && period_done_c) begin
                            start_c = 1'b1;
                        end else begin
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            state_d  = axis_data_gen_enable ? S_WAIT : S_IDLE;
                        end
                    end else begin
                        beat_d  = beat_q + 16'd1;
                        tlast_d = (beat_q + 16'd1) == last_idx_q;
                    end
                end
            end
            S_WAIT: begin
                if (!axis_data_gen_enable) begin
                    state_d = S_IDLE;
                end else if (period_done_c) begin
                    start_c = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        // Packet start: latch length/period, present beat 0 and restart the period count.
        if (start_c) begin
            state_d    = S_SEND;
            beat_d     = 16'd0;
            last_idx_d = (pkt_length == 16'd0) ? 16'd0 : pkt_length - 16'd1;
            per_d      = (period == 16'd0) ? 16'd1 : period;
            cnt_d      = 16'd0;
            tvalid_d   = 1'b1;
            tlast_d    = (last_idx_d == 16'd0);
        end

        tdata_d = tvalid_d ? pattern(seq_d, beat_d) : '0;
        tkeep_d = tvalid_d ? '1 : '0;
    end

    always_ff @(posedge axis_streaming_data_clk or posedge axis_streaming_arst) begin
        if (axis_streaming_arst) begin
            state_q    <= S_IDLE;
            beat_q     <= '0;
            last_idx_q <= '0;
            per_q      <= 16'd1;
            cnt_q      <= '0;
            seq_q      <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            tkeep_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            last_idx_q <= last_idx_d;
            per_q      <= per_d;
            cnt_q      <= cnt_d;
            seq_q      <= seq_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
        end
    end

    assign axis_streaming_data_tx.tdata  = tdata_q;
    assign axis_streaming_data_tx.tvalid = tvalid_q;
    assign axis_streaming_data_tx.tlast  = tlast_q;
    assign axis_streaming_data_tx.tkeep  = tkeep_q;
    assign axis_streaming_data_tx.tuser  = 1'b0;
endmodule

// File: tb/tb_axis_data_generator.sv
// Bench for axis_data_generator: cycle-level packet/period model compared every cycle,
// plus literal expectations on packet counts, gaps and lane contents.
module tb_axis_data_generator;
    localparam int unsigned W      = 1024;
    localparam int unsigned LANES  = W / 64;
    localparam int unsigned KEEP_W = W / 8;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] len;
    logic [15:0] per;

    axis_data_generator_if #(.G_AXIS_DATA_WIDTH(W)) bus ();

    axis_data_generator #(.G_AXIS_DATA_WIDTH(W)) dut (
        .axis_streaming_data_clk (clk),
        .axis_streaming_arst     (rst),
        .axis_data_gen_enable    (en),
        .pkt_length              (len),
        .period                  (per),
        .axis_streaming_data_tx  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Observed statistics, cleared by the stimulus between scenarios.
    int           xfers, tlasts, rises, last_gap, low_run;
    bit           have_first, seen_valid;
    logic [W-1:0] first_data, last_tlast_data;

    function automatic logic [W-1:0] pat(input logic [31:0] seq, input int unsigned beat);
        logic [W-1:0] p;
        for (int unsigned i = 0; i < LANES; i++) p[64*i +: 64] = {seq, 16'(beat), 16'(i)};
        return p;
    endfunction

    function automatic logic [63:0] lane(input logic [W-1:0] d, input int i);
        return d[64*i +: 64];
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int i = 0; i < int'(LANES); i++) begin
                if (lane(act, i) !== lane(exp, i)) begin
                    $display("FAIL %s lane %0d: got 0x%h required 0x%h at %0t",
                             nm, i, lane(act, i), lane(exp, i), $time);
                    break;
                end
            end
        end
    endtask

    task automatic clear_stats();
        xfers = 0; tlasts = 0; rises = 0; last_gap = -1; low_run = 0;
        have_first = 0; seen_valid = 0;
        first_data = '0; last_tlast_data = '0;
    endtask

    // Model: a packet occupies beats 0..L-1; the next one may begin P cycles after the
    // previous start, once the last beat is gone and enable is high; from idle it starts at once.
    bit           m_active, m_idle;
    logic [31:0]  m_seq;
    int unsigned  m_beat, m_len, m_per;
    int           m_start_cyc, cyc;
    bit           prev_stall, prev_valid;
    logic [W-1:0] prev_data;
    logic         prev_last;

    initial begin : compare
        logic [W-1:0]      exp_data;
        logic [KEEP_W-1:0] exp_keep;
        bit                x;
        m_active = 0; m_idle = 1; m_seq = '0; m_beat = 0; m_len = 1; m_per = 1;
        m_start_cyc = 0; cyc = 0; prev_stall = 0; prev_valid = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                m_active = 0; m_idle = 1; m_seq = '0; m_beat = 0;
                prev_stall = 0; prev_valid = 0;
                continue;
            end
            exp_data = m_active ? pat(m_seq, m_beat) : '0;
            exp_keep = m_active ? '1 : '0;
            chk("tvalid", 64'(bus.tvalid), 64'(m_active));
            chk("tlast", 64'(bus.tlast), 64'(m_active && m_beat == m_len - 1));
            chk("tuser", 64'(bus.tuser), 64'd0);
            n_cmp++;
            if (bus.tkeep !== exp_keep) begin
                n_bad++;
                $display("FAIL tkeep: got 0x%0h required 0x%0h at %0t",
                         bus.tkeep[63:0], exp_keep[63:0], $time);
            end
            chk_data("tdata", bus.tdata, exp_data);
            if (prev_stall) begin
                chk("stall_tvalid", 64'(bus.tvalid), 64'd1);
                chk("stall_tlast", 64'(bus.tlast), 64'(prev_last));
                chk_data("stall_tdata", bus.tdata, prev_data);
            end

            if (bus.tvalid) begin
                if (!prev_valid) begin
                    rises++;
                    if (seen_valid) last_gap = low_run;
                    low_run = 0;
                end
                seen_valid = 1;
                if (!have_first) begin have_first = 1; first_data = bus.tdata; end
                if (bus.tready) begin
                    xfers++;
                    if (bus.tlast) begin tlasts++; last_tlast_data = bus.tdata; end
                end
            end else begin
                low_run++;
            end
            prev_valid = bus.tvalid;
            prev_stall = bus.tvalid && !bus.tready;
            prev_data  = bus.tdata;
            prev_last  = bus.tlast;

            x = m_active && bus.tready;
            if (x) begin
                if (m_beat == m_len - 1) begin m_seq = m_seq + 32'd1; m_active = 0; end
                else m_beat++;
            end
            if (!m_active) begin
                if (!en) m_idle = 1;
                else if (m_idle || (cyc + 1 - m_start_cyc) >= int'(m_per)) begin
                    m_active = 1; m_idle = 0; m_beat = 0; m_start_cyc = cyc + 1;
                    m_len = (len == 16'd0) ? 1 : int'(len);
                    m_per = (per == 16'd0) ? 1 : int'(per);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin : stim
        int  guard;
        rst = 1'b1; en = 1'b0; len = '0; per = '0; bus.tready = 1'b1;
        clear_stats();
        cycles(1);
        chk("rst_tvalid", 64'(bus.tvalid), 64'd0);
        chk("rst_tlast", 64'(bus.tlast), 64'd0);
        chk("rst_tkeep", bus.tkeep[63:0], 64'd0);
        chk_data("rst_tdata", bus.tdata, '0);
        cycles(1);
        rst = 1'b0;

        // Idle with enable low.
        cycles(5);
        chk("idle_rises", 64'(rises), 64'd0);

        // One long packet; enable drops mid-packet.
        clear_stats();
        len = 16'd64; per = 16'd128; en = 1'b1;
        cycles(50);
        en = 1'b0;
        cycles(100);
        chk("p64_tlasts", 64'(tlasts), 64'd1);
        chk("p64_xfers", 64'(xfers), 64'd64);
        chk("p64_rises", 64'(rises), 64'd1);
        chk("p64_last_lane5", lane(last_tlast_data, 5), 64'h0000_0000_003F_0005);

        // Short packets with idle gaps.
        clear_stats();
        len = 16'd4; per = 16'd10; en = 1'b1;
        cycles(45);
        en = 1'b0;
        cycles(30);
        chk("p4_first_lane0", lane(first_data, 0), 64'h0000_0001_0000_0000);
        chk("p4_gap", 64'(last_gap), 64'd6);
        chk("p4_tlasts", 64'(tlasts), 64'd5);
        chk("p4_last_lane3", lane(last_tlast_data, 3), 64'h0000_0005_0003_0003);

        // Length exceeds period: back-to-back.
        clear_stats();
        len = 16'd8; per = 16'd4; en = 1'b1;
        cycles(40);
        en = 1'b0;
        cycles(20);
        chk("b2b_rises", 64'(rises), 64'd1);
        chk("b2b_tlasts", 64'(tlasts), 64'd5);
        chk("b2b_xfers", 64'(xfers), 64'd40);

        // Random backpressure, also changing length/period mid-run.
        clear_stats();
        len = 16'd16; per = 16'd8; en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.tready = ($urandom_range(0, 3) != 0);
            if (i == 150) per = 16'd25;
            cycles(1);
        end
        en = 1'b0; bus.tready = 1'b1;
        guard = 0;
        while (bus.tvalid && guard < 40) begin cycles(1); guard++; end
        chk("bp_drain_timeout", 64'(bus.tvalid), 64'd0);
        cycles(2);
        chk("bp_whole_pkts", 64'(xfers), 64'(16 * tlasts));
        chk("bp_some_pkts", 64'(tlasts > 0), 64'd1);

        // Reset mid-packet, then restart from sequence 0.
        len = 16'd32; per = 16'd40; en = 1'b1;
        cycles(10);
        rst = 1'b1;
        #1;
        chk("arst_tvalid", 64'(bus.tvalid), 64'd0);
        chk("arst_tlast", 64'(bus.tlast), 64'd0);
        chk("arst_tkeep", bus.tkeep[63:0], 64'd0);
        chk_data("arst_tdata", bus.tdata, '0);
        cycles(2);
        clear_stats();
        rst = 1'b0;
        cycles(5);
        chk("rst_restart_lane0", lane(first_data, 0), 64'h0000_0000_0000_0000);
        chk("rst_restart_lane1", lane(first_data, 1), 64'h0000_0000_0000_0001);
        en = 1'b0;
        cycles(60);
        chk("rst_restart_tlasts", 64'(tlasts), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
